pmu_quota_sched: RTL
====================

PMU_QUOTA_SCHED -- requirements
Module: pmu_quota_sched

Interface
REQ-001 Parameter N_CORES, default 4: number of per-core quota units that are scheduled.
REQ-002 Parameter REG_WIDTH, default 32: width of the period register and the period counter.
REQ-003 Parameter SETTLE_CYCLES, default 10: cycles after a flush during which quota interrupts are ignored (sequential-sum refill; at least N_COUNTERS+1).
REQ-004 clk_i  in  1  single clock; all flops sample on the rising edge.
REQ-005 rstn_i  in  1  asynchronous reset, active-low.
REQ-006 softrst_i  in  1  synchronous soft reset from configuration registers, active-high.
REQ-007 enable_i  in  1  scheduler enable.
REQ-008 period_i  in  REG_WIDTH  quota replenishment period in cycles; 0 means disabled.
REQ-009 intr_quota_i  in  N_CORES  level quota-exceeded flags from the per-core quota units.
REQ-010 ack_i  in  N_CORES  write-1-to-clear for overrun_o bits.
REQ-011 counters_softrst_o  out  1  one-cycle pulse that clears the event counters and quota sums.
REQ-012 throttle_o  out  N_CORES  per-core stall request.
REQ-013 overrun_o  out  N_CORES  sticky per-core overrun record.
REQ-014 intr_o  out  1  OR of overrun_o.
REQ-015 epoch_o  out  16  count of completed periods; wraps.
REQ-016 period_cnt_o  out  REG_WIDTH  current position within the period.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, FLUSH, SETTLE and RUN, encoded in registered state.
REQ-018 IDLE: when enable_i=1 and period_i!=0, the next state SHALL be FLUSH; otherwise the FSM stays in IDLE.
REQ-019 FLUSH lasts exactly one cycle:
- counters_softrst_o=1;
- period_cnt_o loads 0;
- throttle_o clears to 0;
- next state is SETTLE.
REQ-020 SETTLE lasts exactly SETTLE_CYCLES cycles:
- period_cnt_o increments each cycle;
- intr_quota_i is ignored;
- next state is RUN.
REQ-021 RUN:
- period_cnt_o increments each cycle;
- when period_cnt_o >= period_i-1, the next state SHALL be FLUSH, epoch_o increments by 1 (16-bit wrap) and period_cnt_o wraps to 0.
REQ-022 Period length is period_i cycles measured FLUSH-to-FLUSH. If period_i < SETTLE_CYCLES+2, the effective period SHALL be SETTLE_CYCLES+2 (RUN lasts at least one cycle).
REQ-023 period_i is compared live. A decrease below the current period_cnt_o SHALL cause FLUSH after the next RUN cycle, with no wrap-around miss.
REQ-024 In RUN, intr_quota_i[k]=1 SHALL set throttle_o[k] and overrun_o[k] on the next edge. throttle_o[k] holds until the next FLUSH.
REQ-025 ack_i[k]=1 SHALL clear overrun_o[k]. If set and ack occur in the same cycle, set wins.
REQ-026 intr_o SHALL equal the OR of the registered overrun_o bits, with no combinational path from inputs.
REQ-027 If enable_i=0 or period_i=0 in any non-IDLE state:
- next state is IDLE;
- throttle_o clears;
- period_cnt_o clears;
- overrun_o and epoch_o hold.
REQ-028 In IDLE, counters_softrst_o=0 and throttle_o=0.
REQ-029 The period counter SHALL not overflow. It is held at 0 outside FLUSH, SETTLE and RUN.

Reset
REQ-030 rstn_i=0 SHALL asynchronously force:
- state IDLE;
- all outputs 0;
- period_cnt_o 0;
- epoch_o 0.
REQ-031 softrst_i=1 SHALL synchronously apply the same values as REQ-030. softrst_i has priority over all other inputs.
REQ-032 Reset asserted mid-FLUSH SHALL end the counters_softrst_o pulse immediately; the pulse is never stretched or repeated.

Verification (N_CORES=4, SETTLE_CYCLES=10)
REQ-033 Start-up: enable_i=1, period_i=100 -> counters_softrst_o pulses once at cycle 1, then every 100 cycles; epoch_o=3 after 301 cycles.
REQ-034 Settle masking: intr_quota_i[2]=1 during SETTLE only -> throttle_o[2] and overrun_o[2] remain 0.
REQ-035 Overrun:
- intr_quota_i[1]=1 at period_cnt_o=50 -> throttle_o[1]=1 and intr_o=1 at 51;
- throttle_o[1]=0 in the next FLUSH;
- overrun_o[1] stays 1 until ack_i[1]; an ack in the same cycle as a new set leaves it 1.
REQ-036 Short period: period_i=5 -> FLUSH interval is 12 cycles. Changing period_i from 100 to 20 at period_cnt_o=60 -> FLUSH on the following cycle.
REQ-037 Disable/reset:
- enable_i=0 in RUN -> IDLE next cycle, throttle_o=0, overrun_o held;
- rstn_i low during FLUSH -> counters_softrst_o=0 immediately and all outputs 0.

Source files
------------

// File: rtl/pmu_quota_sched.sv
// rtl/pmu_quota_sched.sv - periodic quota scheduler: flush, settle, then throttle cores on quota overrun
module pmu_quota_sched #(
  parameter int N_CORES       = 4,
  parameter int REG_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 10
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 softrst_i,
  input  logic                 enable_i,
  input  logic [REG_WIDTH-1:0] period_i,
  input  logic [N_CORES-1:0]   intr_quota_i,
  input  logic [N_CORES-1:0]   ack_i,
  output logic                 counters_softrst_o,
  output logic [N_CORES-1:0]   throttle_o,
  output logic [N_CORES-1:0]   overrun_o,
  output logic                 intr_o,
  output logic [15:0]          epoch_o,
  output logic [REG_WIDTH-1:0] period_cnt_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE, RUN} state_t;

  localparam logic [REG_WIDTH-1:0] CNT_ONE    = {{(REG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REG_WIDTH-1:0] SETTLE_END = REG_WIDTH'(SETTLE_CYCLES);

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_CORES-1:0]   throttle_q, throttle_d;
  logic [N_CORES-1:0]   overrun_q, overrun_d;
  logic [15:0]          epoch_q, epoch_d;
  logic                 active;
  logic                 period_done;
  logic                 settle_done;

  assign active      = enable_i && (period_i != '0);
  // cnt+1 >= period avoids the underflow of period-1 and catches a live decrease below cnt
  assign period_done = ({1'b0, cnt_q} + {1'b0, CNT_ONE}) >= {1'b0, period_i};
  assign settle_done = (cnt_q == SETTLE_END);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    throttle_d = throttle_q;
    overrun_d  = overrun_q & ~ack_i;
    epoch_d    = epoch_q;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        throttle_d = '0;
        if (active) state_d = FLUSH;
      end
      FLUSH: begin
        cnt_d      = cnt_q + CNT_ONE;
        throttle_d = '0;
        state_d    = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_ONE;
        if (settle_done) state_d = RUN;
      end
      RUN: begin
        overrun_d = (overrun_q & ~ack_i) | intr_quota_i;
        if (period_done) begin
          state_d    = FLUSH;
          cnt_d      = '0;
          throttle_d = '0;
          epoch_d    = epoch_q + 16'd1;
        end else begin
          cnt_d      = cnt_q + CNT_ONE;
          throttle_d = throttle_q | intr_quota_i;
        end
      end
      default: state_d = IDLE;
    endcase
    // Losing enable or period aborts the schedule but keeps the overrun history and epoch
    if (state_q != IDLE && !active) begin
      state_d    = IDLE;
      cnt_d      = '0;
      throttle_d = '0;
      overrun_d  = overrun_q & ~ack_i;
      epoch_d    = epoch_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      throttle_q <= '0;
      overrun_q  <= '0;
      epoch_q    <= '0;
    end else if (softrst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      throttle_q <= '0;
      overrun_q  <= '0;
      epoch_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      throttle_q <= throttle_d;
      overrun_q  <= overrun_d;
      epoch_q    <= epoch_d;
    end
  end

  assign counters_softrst_o = (state_q == FLUSH);
  assign throttle_o         = throttle_q;
  assign overrun_o          = overrun_q;
  assign intr_o             = |overrun_q;
  assign epoch_o            = epoch_q;
  assign period_cnt_o       = cnt_q;

endmodule
